// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor.
//   state_t    : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   cnt_width  : width of the bit counter for a given operand width
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter only has to reach w-1, so $clog2(w) bits are enough.
    // The floor of 1 keeps the counter a legal vector for tiny widths.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
// Request/result bundle of the bit-serial subtractor.
//   start, a, b, bin          : request side (driven by master)
//   busy, done, diff, bout,
//   overflow                  : status/result side (driven by slave)
// Modports: master = requester, slave = subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, overflow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, overflow
    );
endinterface

// File: rtl/serial_subtractor_cell.sv
// serial_subtractor_cell
// Combinational 1-bit full subtractor: d = m - n - bin.
//   m    : minuend bit
//   n    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module serial_subtractor_cell
    import serial_subtractor_pkg::*;
(
    input  logic m,
    input  logic n,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = m ^ n ^ bin;
    assign bout = (~m & n) | (~m & bin) | (n & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor computing diff = a - b - bin, LSB first, one bit
// per clock through a single full-subtractor cell.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_subtractor_if
//           (start/a/b/bin in; busy/done/diff/bout/overflow out)
// done pulses for one cycle WIDTH edges after the accepting edge; the
// result outputs hold until the next accepted request.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-2:0]  res_sr;
    logic              borrow_q;
    logic              a_msb_q;
    logic              b_msb_q;
    logic [WIDTH-1:0]  diff_q;
    logic              bout_q;
    logic              ovf_q;

    logic              cell_d;
    logic              cell_bout;
    logic              accept;
    logic              last_bit;
    logic [WIDTH-1:0]  res_next;

    serial_subtractor_cell subtractor (
        .m    (a_sr[0]),
        .n    (b_sr[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign accept   = (state_q == IDLE) && bus.start;
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

    // New difference bit enters at the MSB; after the last bit the whole
    // vector is the finished result.
    assign res_next = {cell_d, res_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand MSBs are kept aside because the shift registers lose them,
    // and the overflow rule is stated on the captured operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            borrow_q <= bus.bin;
            cnt_q    <= '0;
            a_msb_q  <= bus.a[WIDTH-1];
            b_msb_q  <= bus.b[WIDTH-1];
        end else if (state_q == SHIFT) begin
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            res_sr   <= res_next[WIDTH-1:1];
            borrow_q <= cell_bout;
            cnt_q    <= cnt_q + 1'b1;
            if (last_bit) begin
                diff_q <= res_next;
                bout_q <= cell_bout;
                ovf_q  <= (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.diff     = diff_q;
    assign bus.bout     = bout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Drives an 8-bit and a 4-bit serial_subtractor. Requests push their
// expected {overflow, bout, diff} into a queue; per-DUT monitors pop and
// compare whenever done is seen.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] exp8_q[$];
    logic [5:0] exp4_q[$];

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word integer subtraction, reduced modulo 2^W;
    // a negative true result means a final borrow.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int         full;
        logic [7:0] d;
        logic       ov;
        full = int'(a) - int'(b) - int'(bin);
        d    = full[7:0];
        ov   = (a[7] != b[7]) && (d[7] != a[7]);
        return {ov, (full < 0), d};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int         full;
        logic [3:0] d;
        logic       ov;
        full = int'(a) - int'(b) - int'(bin);
        d    = full[3:0];
        ov   = (a[3] != b[3]) && (d[3] != a[3]);
        return {ov, (full < 0), d};
    endfunction

    always @(negedge clk) begin
        if (bus8.done) begin
            if (exp8_q.size() == 0) begin
                check_output("unexpected_done8", 32'd1, 32'd0);
            end else begin
                check_output("result8", 32'({bus8.overflow, bus8.bout, bus8.diff}), 32'(exp8_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (bus4.done) begin
            if (exp4_q.size() == 0) begin
                check_output("unexpected_done4", 32'd1, 32'd0);
            end else begin
                check_output("result4", 32'({bus4.overflow, bus4.bout, bus4.diff}), 32'(exp4_q.pop_front()));
            end
        end
    end

    // One 8-bit request. glitch_at re-pulses start with fresh operands
    // after that many edges; reset_at pulls rst_n low after that many edges
    // and abandons the request.
    task automatic apply_stimulus8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                   input logic use_fixed, input logic [9:0] fixed,
                                   input int glitch_at, input int reset_at);
        int   cnt;
        logic got;
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        exp8_q.push_back(use_fixed ? fixed : model8(a, b, bin));
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.bin   = 1'($urandom);
        check_output("busy_after_accept8", 32'(bus8.busy), 32'd1);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 20) begin
            if (cnt == glitch_at) begin
                bus8.start = 1'b1;
                bus8.a     = 8'($urandom);
                bus8.b     = 8'($urandom);
            end
            @(posedge clk); #1;
            cnt++;
            bus8.start = 1'b0;
            if (cnt == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_output("reset_busy", 32'(bus8.busy), 32'd0);
                check_output("reset_done", 32'(bus8.done), 32'd0);
                check_output("reset_result", 32'({bus8.overflow, bus8.bout, bus8.diff}), 32'd0);
                void'(exp8_q.pop_back());
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            got = bus8.done;
        end
        check_output("done_latency8", 32'(cnt), 32'd8);
        @(posedge clk); #1;
        check_output("done_width8", 32'(bus8.done), 32'd0);
        check_output("idle_after8", 32'(bus8.busy), 32'd0);
    endtask

    task automatic apply_stimulus4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int   cnt;
        logic got;
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.bin   = bin;
        exp4_q.push_back(model4(a, b, bin));
        @(posedge clk); #1;
        bus4.start = 1'b0;
        bus4.a     = 4'($urandom);
        bus4.b     = 4'($urandom);
        bus4.bin   = 1'($urandom);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 12) begin
            @(posedge clk); #1;
            cnt++;
            got = bus4.done;
        end
        check_output("done_latency4", 32'(cnt), 32'd4);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.bin   = 1'b0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus4.bin   = 1'b0;
        #12;
        check_output("reset_state8", 32'({bus8.busy, bus8.done, bus8.overflow, bus8.bout, bus8.diff}), 32'd0);
        check_output("reset_state4", 32'({bus4.busy, bus4.done, bus4.overflow, bus4.bout, bus4.diff}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed 8-bit vectors");
        apply_stimulus8(8'h5A, 8'h3C, 1'b0, 1'b1, {1'b0, 1'b0, 8'h1E}, -1, -1);
        apply_stimulus8(8'h00, 8'h01, 1'b0, 1'b1, {1'b0, 1'b1, 8'hFF}, -1, -1);
        apply_stimulus8(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b0, 8'h7F}, -1, -1);
        apply_stimulus8(8'h10, 8'h0F, 1'b1, 1'b1, {1'b0, 1'b0, 8'h00}, -1, -1);

        $display("[TB] start while busy");
        apply_stimulus8(8'hC3, 8'h2A, 1'b0, 1'b1, {1'b0, 1'b0, 8'h99}, 3, -1);

        $display("[TB] reset mid-operation");
        apply_stimulus8(8'h55, 8'h22, 1'b0, 1'b0, 10'd0, -1, 4);
        @(posedge clk); #1;
        apply_stimulus8(8'h03, 8'h05, 1'b0, 1'b1, {1'b0, 1'b1, 8'hFE}, -1, -1);

        $display("[TB] random 8-bit vectors");
        for (int i = 0; i < 40; i++) begin
            apply_stimulus8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 10'd0,
                            ((i % 5) == 0) ? int'($urandom_range(6)) : -1, -1);
        end

        $display("[TB] exhaustive 4-bit sweep");
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    apply_stimulus4(4'(ai), 4'(bi), 1'(ci));
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check_output("queue8_drained", 32'(exp8_q.size()), 32'd0);
        check_output("queue4_drained", 32'(exp4_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
